// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
// The queue entry packs the PC above the instruction word.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [1:0] FS_REQ   = 2'd0;
  localparam logic [1:0] FS_WAIT  = 2'd1;
  localparam logic [1:0] FS_DRAIN = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for the prefetch queue.
// The head is read combinationally so the datapath sees it without an extra cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       push_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == DEPTH_CNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, one outstanding memory
// transaction, prefetch queue toward the datapath, and redirect handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [1:0]   state_reg, state_next;
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic [31:0]  last_pc_reg;
  logic         push, pop, full, empty;
  logic [AW:0]  count;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  // Request only depends on registered state, so it is stable until granted.
  assign imem_req  = rst && (state_reg == FS_REQ) && (count < DEPTH_CNT);
  assign imem_addr = fetch_pc_reg;

  assign push            = (state_reg == FS_WAIT) && imem_rvalid && !redirect && !full;
  assign pop             = inst_valid && inst_ready;
  assign push_entry.pc   = fetch_pc_reg;
  assign push_entry.inst = imem_rdata;

  assign inst_valid = !empty;
  assign inst       = empty ? NOP_INST : head.inst;
  assign inst_pc    = empty ? last_pc_reg : head.pc;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data (push_entry),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FS_REQ: begin
        // A grant coinciding with redirect fetches a stale word; drain it.
        if (imem_req && imem_gnt) state_next = redirect ? FS_DRAIN : FS_WAIT;
      end
      FS_WAIT: begin
        if (imem_rvalid)   state_next = FS_REQ;
        else if (redirect) state_next = FS_DRAIN;
      end
      FS_DRAIN: begin
        if (imem_rvalid) state_next = FS_REQ;
      end
      default: state_next = FS_REQ;
    endcase
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect)  fetch_pc_next = word_align(redirect_pc);
    else if (push) fetch_pc_next = fetch_pc_reg + 32'd4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= FS_REQ;
      fetch_pc_reg <= RESET_PC;
      last_pc_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (!empty) last_pc_reg <= head.pc;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle datapath.
- Generates sequential PCs and issues requests to a variable-latency instruction memory using a req/gnt/rvalid handshake.
- Buffers returned words in a small prefetch queue and presents {inst, pc} to the datapath with a valid/ready handshake.
- A redirect input (taken branch/jump) flushes the queue and discards any in-flight fetch.

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; bits[1:0] always 0.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  queue head is valid.
- inst  out  32  queue head instruction.
- inst_pc  out  32  PC of queue head.
- inst_ready  in  1  datapath consumes head this cycle.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC; bits[1:0] forced to 0 internally.

Behaviour:
- Reset (rst=0):
  - State REQ, fetch_pc=RESET_PC, queue empty.
  - imem_req=0 while rst=0.
  - imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=0.
- At most one outstanding memory transaction.
- States:
  - REQ:
    - imem_req=1 iff queue count < DEPTH; imem_addr=fetch_pc.
    - imem_req && imem_gnt -> WAIT_RESP.
  - WAIT_RESP:
    - imem_req=0.
    - On imem_rvalid: push {fetch_pc, imem_rdata}, fetch_pc += 4, -> REQ.
  - DRAIN:
    - imem_req=0.
    - On imem_rvalid: discard data, no push, -> REQ.
- Request stability: once imem_req=1, imem_req and imem_addr stay constant until gnt. The only exception is redirect, which may change the address or drop the request.
- Zero-wait memory (gnt with req, rvalid next cycle): throughput is one instruction per 2 cycles. inst_valid rises the cycle after rvalid (registered queue, no bypass).
- Pop:
  - Pop occurs when inst_valid && inst_ready.
  - The head advances at the clock edge.
  - A simultaneous pop and push is legal at any count < DEPTH.
- Queue outputs when empty: inst_valid=0, inst=NOP, inst_pc holds its last value.
- Redirect (highest priority, single cycle):
  - Queue flushed; a same-cycle pop is still considered consumed.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - From REQ with imem_req && imem_gnt in the same cycle -> DRAIN (the granted fetch is stale).
  - From REQ without gnt -> REQ; the new address appears next cycle.
  - From WAIT_RESP without rvalid -> DRAIN.
  - From WAIT_RESP with rvalid in the same cycle -> REQ; the response is dropped.
  - From DRAIN -> DRAIN, unless rvalid arrives the same cycle, then -> REQ.
  - inst_valid=0 in the cycle after redirect.
- fetch_pc wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- imem_rvalid in REQ state is a protocol violation and is ignored.
- Reset asserted mid-transaction: all state is cleared immediately. The memory is assumed to be reset by the same rst.

Decomposition:
- defines.v gains:
  - `NOP_INST 32'h0000_0013
  - fetch state encodings FS_REQ, FS_WAIT, FS_DRAIN (2-bit)
- Sub-module fetch_fifo:
  - Synchronous FIFO with parameters DEPTH and WIDTH=64.
  - Ports: push, pop, flush, count, full, empty, head.
  - flush overrides push/pop.

Test Plan:
- Sequential fetch, zero-wait memory returning addr as data, inst_ready=1 -> inst_pc sequence 0,4,8,12 on inst_valid cycles; inst equals the PC.
- Backpressure, inst_ready=0 for 20 cycles -> exactly 4 entries queued, then imem_req=0. Raising inst_ready drains pc 0..12 in order, and imem_req reasserts the cycle after the first pop.
- Redirect to 32'h0000_0102 while WAIT_RESP with 3-cycle rvalid latency -> stale word not queued. Next imem_addr=32'h0000_0100 only after the stale rvalid. First delivered inst_pc=32'h100.
- Redirect in the same cycle as imem_req && imem_gnt (pc 8), redirect_pc=32'h40 -> state DRAIN, pc 8 response dropped. Next request addr 32'h40.
- RESET_PC=32'hFFFF_FFF8 -> fetched PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst pulsed low while WAIT_RESP with 2 entries queued -> next cycle inst_valid=0, imem_req=0, inst=32'h0000_0013. After release, fetch restarts at RESET_PC.
